// File: rtl/frame_addr_ctrl.sv
// Frame-buffer address controller: independent read/write SDRAM pixel address
// channels with auto-increment, direct pixel writes and double-buffered banks.
module frame_addr_ctrl #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BANK_BASE = 131072,
  parameter int unsigned ROW_BASE  = 1,
  parameter int unsigned WRAP      = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Read,
  input  logic              Write,
  input  logic              Mode,
  input  logic [9:0]        Row_Data,
  input  logic [9:0]        Col_Data,
  input  logic              R_Busy,
  input  logic              W_Busy,
  input  logic              Swap_Req,
  output logic [ADDR_W-1:0] R_Address,
  output logic [ADDR_W-1:0] W_Address,
  output logic              R_Done,
  output logic              W_Done,
  output logic              R_Frame_End,
  output logic              W_Frame_End,
  output logic              Coord_Err,
  output logic              Bank
);

  localparam int unsigned FRAME_SIZE = H_RES * V_RES;
  localparam int unsigned OFF_W      = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(FRAME_SIZE - 1);
  localparam logic [ADDR_W-1:0] BANK1    = ADDR_W'(BANK_BASE);

  typedef enum logic {R_IDLE, R_WAIT} r_state_t;
  typedef enum logic {W_IDLE, W_WAIT} w_state_t;

  r_state_t         r_state_q, r_state_n;
  w_state_t         w_state_q, w_state_n;
  logic [OFF_W-1:0] r_off_q, r_off_n;
  logic [OFF_W-1:0] w_off_q, w_off_n;
  logic             bank_n;
  logic             pend_q, pend_n;
  logic             r_busy_q, w_busy_q;
  logic             r_done_n, w_done_n, r_fe_n, w_fe_n, cerr_n;
  logic             r_cmpl, w_cmpl, swap;
  logic             coord_bad;
  int unsigned      row_u, col_u;
  logic [OFF_W-1:0] load_off;

  function automatic logic [OFF_W-1:0] advance(input logic [OFF_W-1:0] off);
    if (off != LAST_OFF)
      return off + OFF_W'(1);
    else if (WRAP != 0)
      return '0;
    else
      return off;
  endfunction

  always_comb begin
    r_state_n = r_state_q;
    w_state_n = w_state_q;
    r_off_n   = r_off_q;
    w_off_n   = w_off_q;
    bank_n    = Bank;
    pend_n    = pend_q | Swap_Req;
    r_done_n  = 1'b0;
    w_done_n  = 1'b0;
    r_fe_n    = 1'b0;
    w_fe_n    = 1'b0;
    cerr_n    = 1'b0;
    swap      = 1'b0;

    row_u     = 32'(Row_Data);
    col_u     = 32'(Col_Data);
    coord_bad = (row_u < ROW_BASE) || ((row_u - ROW_BASE) >= V_RES) || (col_u >= H_RES);
    load_off  = OFF_W'((row_u - ROW_BASE) * H_RES + col_u);

    // Completion is a falling edge of busy seen while waiting.
    r_cmpl = (r_state_q == R_WAIT) && r_busy_q && !R_Busy;
    w_cmpl = (w_state_q == W_WAIT) && w_busy_q && !W_Busy;

    case (r_state_q)
      R_IDLE: if (Read) r_state_n = R_WAIT;
      R_WAIT: if (r_cmpl) begin
        r_state_n = R_IDLE;
        r_done_n  = 1'b1;
        r_off_n   = advance(r_off_q);
        r_fe_n    = (r_off_q == LAST_OFF) && (WRAP != 0);
      end
      default: r_state_n = R_IDLE;
    endcase

    case (w_state_q)
      W_IDLE: if (Write) begin
        if (!Mode) begin
          w_state_n = W_WAIT;
        end else if (coord_bad) begin
          cerr_n = 1'b1;
        end else begin
          w_state_n = W_WAIT;
          w_off_n   = load_off;
        end
      end
      W_WAIT: if (w_cmpl) begin
        w_state_n = W_IDLE;
        w_done_n  = 1'b1;
        w_off_n   = advance(w_off_q);
        w_fe_n    = (w_off_q == LAST_OFF) && (WRAP != 0);
      end
      default: w_state_n = W_IDLE;
    endcase

    // A pending swap lands on the read frame boundary and overrides any write-offset update.
    swap = r_fe_n && pend_q;
    if (swap) begin
      bank_n  = ~Bank;
      w_off_n = '0;
      pend_n  = Swap_Req;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state_q   <= R_IDLE;
      w_state_q   <= W_IDLE;
      r_off_q     <= '0;
      w_off_q     <= '0;
      Bank        <= 1'b0;
      pend_q      <= 1'b0;
      r_busy_q    <= 1'b0;
      w_busy_q    <= 1'b0;
      R_Done      <= 1'b0;
      W_Done      <= 1'b0;
      R_Frame_End <= 1'b0;
      W_Frame_End <= 1'b0;
      Coord_Err   <= 1'b0;
      R_Address   <= '0;
      W_Address   <= BANK1;
    end else begin
      r_state_q   <= r_state_n;
      w_state_q   <= w_state_n;
      r_off_q     <= r_off_n;
      w_off_q     <= w_off_n;
      Bank        <= bank_n;
      pend_q      <= pend_n;
      r_busy_q    <= R_Busy;
      w_busy_q    <= W_Busy;
      R_Done      <= r_done_n;
      W_Done      <= w_done_n;
      R_Frame_End <= r_fe_n;
      W_Frame_End <= w_fe_n;
      Coord_Err   <= cerr_n;
      R_Address   <= ADDR_W'(r_off_n) + (bank_n ? BANK1 : '0);
      W_Address   <= ADDR_W'(w_off_n) + (bank_n ? '0 : BANK1);
    end
  end

endmodule

// File: doc/frame_addr_ctrl.md
Name: frame_addr_ctrl

Overview:
Parametrised successor to the frame-buffer address controller. Generates read (display) and write (draw) SDRAM pixel addresses with independent per-channel handshakes, and auto-increments each channel on access completion. Supports direct pixel-addressed writes, wrap or saturate at frame end, and double buffering with a bank swap synchronised to the read frame boundary. Sits between the pixel producer/display scan logic and the SDRAM controller.

Parameters:
H_RES, 320, pixels per row
V_RES, 240, rows per frame
ADDR_W, 20, address output width
BANK_BASE, 131072, address offset of bank 1; bank 0 starts at 0
ROW_BASE, 1, row index of the first row on Row_Data (1 means 1-based rows)
WRAP, 1, 1: offset wraps to 0 after FRAME_SIZE-1; 0: offset saturates at FRAME_SIZE-1

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Read  in  1  read request, sampled in R_IDLE
Write  in  1  write request, sampled in W_IDLE
Mode  in  1  on write acceptance: 1 = load pixel offset from Row_Data/Col_Data; 0 = sequential
Row_Data  in  10  pixel row for Mode=1
Col_Data  in  10  pixel column for Mode=1
R_Busy  in  1  SDRAM busy with read access
W_Busy  in  1  SDRAM busy with write access
Swap_Req  in  1  one-cycle pulse requesting a bank swap
R_Address  out  ADDR_W  current read address
W_Address  out  ADDR_W  current write address
R_Done  out  1  one-cycle pulse on read completion
W_Done  out  1  one-cycle pulse on write completion
R_Frame_End  out  1  one-cycle pulse when read offset passes FRAME_SIZE-1
W_Frame_End  out  1  one-cycle pulse when write offset passes FRAME_SIZE-1
Coord_Err  out  1  one-cycle pulse on a rejected Mode=1 write
Bank  out  1  display (read) bank; the write bank is always ~Bank

Behaviour:
- FRAME_SIZE = H_RES*V_RES. Last valid offset = FRAME_SIZE-1 (76799 at defaults). Offsets are held in registers R_Off and W_Off.
- R_Address = R_Off + (Bank ? BANK_BASE : 0). W_Address = W_Off + (Bank ? 0 : BANK_BASE). Sums are truncated to ADDR_W. Both outputs are registered and update on the same edge as their sources.
- Reset (async, Reset_n=0): R_Off=0, W_Off=0, Bank=0, swap-pending=0, both FSMs idle, all pulse outputs 0. Resulting outputs: R_Address=0, W_Address=BANK_BASE.
- Read FSM states: R_IDLE and R_WAIT.
  - R_IDLE & Read=1 -> R_WAIT.
  - In R_WAIT, completion is a falling edge of R_Busy: registered R_Busy_q=1 and R_Busy=0 at the same edge.
  - On completion: advance R_Off, pulse R_Done for 1 cycle, return to R_IDLE.
  - Read while in R_WAIT is ignored. No request is accepted on the completion cycle.
- Write FSM states: W_IDLE and W_WAIT. Same rules as the read FSM, using Write/W_Busy/W_Done.
  - Mode=1 at acceptance: row index = Row_Data - ROW_BASE.
  - If row index < 0, row index >= V_RES, or Col_Data >= H_RES: pulse Coord_Err, stay in W_IDLE, leave W_Off unchanged.
  - Otherwise W_Off = row*H_RES + Col_Data on the acceptance edge, then enter W_WAIT.
- Advance rule (both channels): offset < FRAME_SIZE-1 -> offset+1.
  - At FRAME_SIZE-1 with WRAP=1: offset becomes 0 and the channel's Frame_End pulses together with Done.
  - At FRAME_SIZE-1 with WRAP=0: offset holds and no Frame_End pulse.
- Bank swap:
  - Swap_Req sets swap-pending.
  - On the R_Frame_End edge with pending=1: toggle Bank, set W_Off=0, clear pending. If a write completion occurs on that same edge, W_Off=0 takes priority.
  - Swap_Req arriving on that same edge re-arms pending for the next frame.
  - When WRAP=0 no swap ever occurs.
- The read and write channels are fully independent. Simultaneous requests and completions on both channels are each processed in the same cycle.
- Reset_n asserted mid-access aborts immediately. Any R_Busy/W_Busy fall after release is ignored because both FSMs are idle.

Test Plan:
- Reset release, no activity -> R_Address=0, W_Address=131072, Bank=0, all pulses 0.
- Three sequential writes (Write pulse, W_Busy 1 for 4 cycles then 0) -> one W_Done per access; W_Address reaches 131075; R_Address stays 0.
- Mode=1, Row_Data=2, Col_Data=5 -> W_Address=131397 on the acceptance edge, 131398 after completion. Then Row_Data=0 or Col_Data=320 -> Coord_Err pulse, W_Address unchanged, no W_Done.
- Swap_Req pulse, then 76800 reads -> on the last completion: R_Done and R_Frame_End both pulse, Bank=1, R_Address=131072, W_Address=0. Repeat the frame with WRAP=0 -> R_Address sticks at 76799, no R_Frame_End.
- Read and Write accepted the same cycle, busy falls the same cycle -> R_Done and W_Done pulse together and both offsets advance by 1.
- Reset_n dropped while in R_WAIT with R_Off=10 -> outputs return to reset values immediately. A later R_Busy fall produces no R_Done.
